// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: operation codes (also used by
// the ALU controller), datapath width, and the execution FSM states.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_ADD = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SRA = 4'b0110,
    OP_SLL = 4'b0111,
    OP_SLA = 4'b1000,
    OP_EQ  = 4'b1001,
    OP_NE  = 4'b1010,
    OP_LT  = 4'b1011,
    OP_GE  = 4'b1100,
    OP_LUI = 4'b1101
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_t;

  // Shift ops are the only ones that take the iterative path.
  function automatic logic op_is_shift(input logic [3:0] op);
    op_is_shift = (op == OP_SRL) || (op == OP_SRA) ||
                  (op == OP_SLL) || (op == OP_SLA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations: logic, add/sub, signed compares and LUI.
// Shift codes and the two unused codes produce zero here; shifts are handled
// by the iterative datapath in the top level.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  alu_op_t           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;

  assign w_a_s = i_a;
  assign w_b_s = i_b;

  // Result select; compares return the flag in bit 0 with the rest cleared.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_EQ:   o_result = {{(DATA_W-1){1'b0}}, (i_a == i_b)};
      OP_NE:   o_result = {{(DATA_W-1){1'b0}}, (i_a != i_b)};
      OP_LT:   o_result = {{(DATA_W-1){1'b0}}, (w_a_s <  w_b_s)};
      OP_GE:   o_result = {{(DATA_W-1){1'b0}}, (w_a_s >= w_b_s)};
      OP_LUI:  o_result = i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// ALU execution unit with valid/ready on both sides. Single-cycle ops finish
// one cycle after accept; shifts iterate one bit per cycle in the result
// register, so a shift by N delivers its result N+1 cycles after accept.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero
);

  localparam int SHAMT_W = $clog2(DATA_W);

  alu_state_t         r_state;
  alu_state_t         w_next;
  alu_op_t            r_op;
  logic [DATA_W-1:0]  r_result;
  logic [SHAMT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  w_core_result;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;

  // One step of the iterative shifter; SLA behaves exactly like SLL.
  function automatic logic [DATA_W-1:0] shift_one(input alu_op_t op,
                                                  input logic [DATA_W-1:0] v);
    case (op)
      OP_SRL:  shift_one = {1'b0, v[DATA_W-1:1]};
      OP_SRA:  shift_one = {v[DATA_W-1], v[DATA_W-1:1]};
      default: shift_one = {v[DATA_W-2:0], 1'b0};
    endcase
  endfunction

  // Only the low SHAMT_W bits of SrcB form the shift amount.
  assign w_shamt    = SrcB[SHAMT_W-1:0];
  assign w_is_shift = op_is_shift(Operation);

  alu_comb_core #(.DATA_W(DATA_W)) u_core (
    .i_op     (alu_op_t'(Operation)),
    .i_a      (SrcA),
    .i_b      (SrcB),
    .o_result (w_core_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs; a zero-length shift skips SHIFT.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (w_is_shift && (w_shamt != '0)) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == SHAMT_W'(1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and shift iteration; the result register doubles as the
  // shift working register and holds steady throughout DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_cnt    <= '0;
      r_op     <= OP_AND;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op     <= alu_op_t'(Operation);
            r_cnt    <= w_shamt;
            r_result <= w_is_shift ? SrcA : w_core_result;
          end
        end
        ST_SHIFT: begin
          r_result <= shift_one(r_op, r_result);
          r_cnt    <= r_cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ALUResult = r_result;
  assign Zero      = out_valid && (r_result == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases with literal expectations, then
// randomized traffic with random backpressure checked every cycle against a
// transaction-level model (result from plain arithmetic, latency 1+shamt).
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: one outstanding transaction, cycles left before valid.
  bit          m_pending = 1'b0;
  int          m_wait    = 0;
  logic [31:0] m_result  = '0;

  always #5 clk = ~clk;

  alu_multicycle dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = 32'(b[4:0]);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a ^ b;
      4'd3:  return a + b;
      4'd4:  return a - b;
      4'd5:  return a >> sh;
      4'd6:  return 32'($signed(a) >>> sh);
      4'd7,
      4'd8:  return a << sh;
      4'd9:  return {31'b0, a == b};
      4'd10: return {31'b0, a != b};
      4'd11: return {31'b0, $signed(a) <  $signed(b)};
      4'd12: return {31'b0, $signed(a) >= $signed(b)};
      4'd13: return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd5 && op <= 4'd8 && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Transaction-level model update on each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      m_pending <= 1'b0;
    end else if (m_pending) begin
      if (m_wait > 0)     m_wait    <= m_wait - 1;
      else if (out_ready) m_pending <= 1'b0;
    end else if (in_valid) begin
      m_pending <= 1'b1;
      m_result  <= ref_alu(Operation, SrcA, SrcB);
      m_wait    <= ref_lat(Operation, SrcB) - 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk1("cyc in_ready", in_ready, !m_pending);
      chk1("cyc out_valid", out_valid, m_pending && (m_wait == 0));
      if (m_pending && m_wait == 0) begin
        chk("cyc ALUResult", ALUResult, m_result);
        chk1("cyc Zero", Zero, m_result == 32'h0);
      end
    end
  end

  // Issue one op, measure latency, optionally stall the output, then drain.
  task automatic do_op(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_lat,
                       input int stall, input bit junk);
    int lat;
    bit got;
    @(posedge clk); #1;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    chk1({name, " ready before accept"}, in_ready, 1'b1);
    @(posedge clk); #1;
    if (junk) begin
      Operation = 4'd3; SrcA = $urandom; SrcB = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      chk1({name, " busy ready"}, in_ready, 1'b0);
      if (out_valid) got = 1'b1;
    end
    chk1({name, " valid within bound"}, got, 1'b1);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, ALUResult, exp_r);
    chk1({name, " zero"}, Zero, exp_r == 32'h0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1({name, " stall valid"}, out_valid, 1'b1);
      chk({name, " stall result"}, ALUResult, exp_r);
      chk1({name, " stall ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1({name, " idle ready"}, in_ready, 1'b1);
    chk1({name, " idle valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int  stale;
    bit  acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'd0; SrcA = '0; SrcB = '0;

    // Pin the model with hand-computed values.
    chk("model add",  ref_alu(4'd3, 32'h7FFFFFFF, 32'h1), 32'h80000000);
    chk("model sra",  ref_alu(4'd6, 32'h80000000, 32'h104), 32'hF8000000);
    chk("model lt",   ref_alu(4'd11, 32'hFFFFFFFF, 32'h1), 32'h1);
    chk("model lat4", 32'(ref_lat(4'd6, 32'h104)), 32'd5);
    chk("model lat31", 32'(ref_lat(4'd7, 32'h1F)), 32'd32);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset out_valid", out_valid, 1'b0);
    chk("reset ALUResult", ALUResult, 32'h0);
    chk1("reset Zero", Zero, 1'b0);
    chk_en = 1'b1;

    do_op("add",   4'd3,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1,  0, 1'b0);
    do_op("sub",   4'd4,  32'h5,        32'h5,        32'h0,        1,  0, 1'b0);
    do_op("sra4",  4'd6,  32'h80000000, 32'h104,      32'hF8000000, 5,  0, 1'b0);
    do_op("sll0",  4'd7,  32'h1,        32'h0,        32'h1,        1,  0, 1'b0);
    do_op("sll31", 4'd7,  32'h1,        32'h1F,       32'h80000000, 32, 0, 1'b0);
    do_op("lt",    4'd11, 32'hFFFFFFFF, 32'h1,        32'h1,        1,  0, 1'b0);
    do_op("ge",    4'd12, 32'hFFFFFFFF, 32'h1,        32'h0,        1,  0, 1'b0);
    do_op("eq",    4'd9,  32'h7,        32'h7,        32'h1,        1,  0, 1'b0);
    do_op("ne",    4'd10, 32'h7,        32'h7,        32'h0,        1,  0, 1'b0);
    do_op("sla2",  4'd8,  32'h3,        32'hFFFFFFE2, 32'hC,        3,  0, 1'b0);
    do_op("srl31", 4'd5,  32'h80000000, 32'h1F,       32'h1,        32, 0, 1'b0);
    do_op("lui",   4'd13, 32'hDEAD0000, 32'h12345000, 32'h12345000, 1,  0, 1'b0);
    do_op("op14",  4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1,  0, 1'b0);
    do_op("bp xor",4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1,  3, 1'b1);

    // Reset in the middle of a 20-step SRL: nothing must come out afterwards.
    @(posedge clk); #1;
    Operation = 4'd5; SrcA = 32'hFFFFFFFF; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("midreset out_valid", out_valid, 1'b0);
    chk1("midreset in_ready", in_ready, 1'b1);
    chk("midreset ALUResult", ALUResult, 32'h0);
    chk1("midreset Zero", Zero, 1'b0);
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midreset stale results", 32'(stale), 32'd0);

    // Randomized traffic with random backpressure; the producer holds its
    // request until accepted.
    acc = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        in_valid  = 1'b1;
        Operation = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 4))
          0:       SrcA = 32'h0;
          1:       SrcA = 32'hFFFFFFFF;
          2:       SrcA = 32'h80000000;
          default: SrcA = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       SrcB = SrcA;
          1:       SrcB = 32'($urandom_range(0, 7)) | ($urandom & 32'hFFFFFFE0);
          default: SrcB = $urandom;
        endcase
      end
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk1("drain idle", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
